// File: rtl/band_seq_ctrl.sv
// Sequencer for a bank of FIR band engines sharing one circular sample queue.
// Optional sticky overrun flag is enabled by defining OVRN_STICKY_EN.
module band_seq_ctrl #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_vld,
  output logic                     wrt_en,
  output logic [$clog2(DEPTH)-1:0] wrt_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic                     seq,
  output logic                     out_vld,
  output logic                     busy,
  output logic                     ovrn
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] TAPS_W   = AW'(TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] ZERO     = {AW{1'b0}};

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wrt_ptr_nxt, rd_ptr_nxt;
  logic          out_vld_nxt, seq_nxt, busy_nxt;
  logic          accept;

  // Samples are only taken while not busy; the write strobe is combinational.
  assign accept = sample_vld & ((state == FILL) | (state == IDLE));
  assign wrt_en = accept & rst_n;

  // Next-state, counter and pointer logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wrt_ptr_nxt = wrt_ptr;
    rd_ptr_nxt  = rd_ptr;
    out_vld_nxt = 1'b0;

    if (accept) begin
      wrt_ptr_nxt = wrt_ptr + ONE;
    end else begin
      wrt_ptr_nxt = wrt_ptr;
    end

    case (state)
      FILL: begin
        if (accept) begin
          if (cnt == LAST_TAP) begin
            state_nxt = IDLE;
            cnt_nxt   = ZERO;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      IDLE: begin
        if (accept) begin
          state_nxt  = RUN;
          cnt_nxt    = ZERO;
          // oldest retained sample: the newest is the one written now
          rd_ptr_nxt = wrt_ptr + ONE - TAPS_W;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST_TAP) begin
          state_nxt = DRAIN;
          cnt_nxt   = ZERO;
        end else begin
          cnt_nxt    = cnt + ONE;
          rd_ptr_nxt = rd_ptr + ONE;
        end
      end
      DRAIN: begin
        if (cnt == ONE) begin
          state_nxt   = IDLE;
          cnt_nxt     = ZERO;
          out_vld_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = ZERO;
      end
    endcase

    seq_nxt  = (state_nxt == RUN);
    busy_nxt = (state_nxt == RUN) | (state_nxt == DRAIN);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= ZERO;
      wrt_ptr <= ZERO;
      rd_ptr  <= ZERO;
      out_vld <= 1'b0;
      seq     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wrt_ptr <= wrt_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      out_vld <= out_vld_nxt;
      seq     <= seq_nxt;
      busy    <= busy_nxt;
    end
  end

`ifdef OVRN_STICKY_EN
  // Sticky overrun: any sample arriving while busy is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovrn <= 1'b0;
    end else begin
      ovrn <= ovrn | (sample_vld & busy);
    end
  end
`else
  assign ovrn = 1'b0;
`endif

endmodule

// File: tb/tb_band_seq_ctrl.sv
// Self-checking bench for band_seq_ctrl (DEPTH=16, TAPS=8) using a timestamp-based model.
module tb_band_seq_ctrl;
  localparam int DEPTH = 16;
  localparam int TAPS  = 8;
`ifdef OVRN_STICKY_EN
  localparam int OVRN_ON = 1;
`else
  localparam int OVRN_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_vld = 1'b0;
  logic       wrt_en, seq, out_vld, busy, ovrn;
  logic [3:0] wrt_ptr, rd_ptr;

  band_seq_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_vld(sample_vld), .wrt_en(wrt_en),
    .wrt_ptr(wrt_ptr), .rd_ptr(rd_ptr), .seq(seq), .out_vld(out_vld),
    .busy(busy), .ovrn(ovrn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run started at cycle s occupies RUN s+1..s+TAPS, DRAIN the next 2, out_vld after.
  int cyc = 0;
  int writes = 0;
  int start_cyc = -100;
  int start_wp = 0;
  int ovrn_m = 0;
  int rel, rd_m;
  int seq_m, busy_m, outv_m, acc_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      writes = 0;
      start_cyc = -100;
      ovrn_m = 0;
      check("rst_wrt_en", wrt_en, 0);
      check("rst_wrt_ptr", wrt_ptr, 0);
      check("rst_rd_ptr", rd_ptr, 0);
      check("rst_seq", seq, 0);
      check("rst_busy", busy, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_ovrn", ovrn, 0);
    end else begin
      rel    = cyc - start_cyc;
      seq_m  = (rel >= 1 && rel <= TAPS) ? 1 : 0;
      busy_m = (rel >= 1 && rel <= TAPS + 2) ? 1 : 0;
      outv_m = (rel == TAPS + 3) ? 1 : 0;
      acc_m  = (sample_vld && busy_m == 0) ? 1 : 0;
      check("wrt_en", wrt_en, acc_m);
      check("wrt_ptr", wrt_ptr, writes % DEPTH);
      check("seq", seq, seq_m);
      check("busy", busy, busy_m);
      check("out_vld", out_vld, outv_m);
      check("ovrn", ovrn, ovrn_m);
      if (seq_m == 1) begin
        rd_m = (((start_wp + 1 - TAPS + rel - 1) % DEPTH) + DEPTH) % DEPTH;
        check("rd_ptr", rd_ptr, rd_m);
      end
      if (acc_m == 1) begin
        if (writes >= TAPS) begin
          start_cyc = cyc;
          start_wp  = writes % DEPTH;
        end
        writes++;
      end
      if (sample_vld && busy_m == 1 && OVRN_ON == 1) ovrn_m = 1;
    end
    cyc++;
  end

  task automatic step(input logic v);
    @(posedge clk);
    #1 sample_vld = v;
  endtask

  int wrap_exp [8] = '{12, 13, 14, 15, 0, 1, 2, 3};

  initial begin
    #2 check("reset_all", {25'd0, seq, busy, wrt_en, out_vld, ovrn, wrt_ptr, rd_ptr}, 0);
    repeat (3) @(posedge clk);
    // first edge after release carries a FILL write
    #1 rst_n = 1'b1;
    sample_vld = 1'b1;
    step(1'b0);
    repeat (6) begin step(1'b1); step(1'b0); end
    @(negedge clk);
    check("prime7_wrt_ptr", wrt_ptr, 7);
    check("prime7_seq", seq, 0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    check("prime8_no_run", busy, 0);
    check("prime8_wrt_ptr", wrt_ptr, 8);

    // first run: written at 8, reads 1..8
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    check("run1_seq", seq, 1);
    check("run1_rd_first", rd_ptr, 1);
    repeat (9) step(1'b0);
    step(1'b1);
    @(negedge clk);
    check("b2b_out_vld", out_vld, 1);
    check("b2b_wrt_en", wrt_en, 1);
    check("b2b_busy", busy, 0);

    // overrun on RUN cycle 4
    repeat (3) step(1'b0);
    step(1'b1);
    @(negedge clk);
    check("ovr_wrt_en", wrt_en, 0);
    step(1'b0);
    @(negedge clk);
    check("ovr_wrt_ptr", wrt_ptr, 10);
    repeat (5) step(1'b0);

    // walk wrt_ptr around to 3
    repeat (9) begin
      step(1'b1);
      repeat (10) step(1'b0);
    end
    step(1'b1);
    @(negedge clk);
    check("wrap_wrt_ptr", wrt_ptr, 3);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      @(negedge clk);
      check("wrap_rd_ptr", rd_ptr, wrap_exp[i]);
    end
    repeat (2) step(1'b0);
    step(1'b1);
    @(negedge clk);
    check("ovrn_sticky", ovrn, OVRN_ON);

    // reset during RUN cycle 3
    repeat (3) step(1'b0);
    #1 rst_n = 1'b0;
    #1 check("midrst_outputs", {25'd0, seq, busy, wrt_en, out_vld, ovrn, wrt_ptr, rd_ptr}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample_vld = 1'b1;
    step(1'b0);
    repeat (6) begin step(1'b1); step(1'b0); end
    step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    check("reprime_no_run", busy, 0);
    check("reprime_wrt_ptr", wrt_ptr, 8);
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    check("reprime_run_seq", seq, 1);
    check("reprime_run_rd", rd_ptr, 1);
    repeat (12) step(1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end
endmodule
